// File: rtl/rv32i_types.sv
// Shared types and constants for the RV32I front end.
package rv32i_types;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;

  // Saturating 2-bit counter step up.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : (c + 2'b01);
  endfunction

  // Saturating 2-bit counter step down.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : (c - 2'b01);
  endfunction

endpackage

// File: rtl/if_fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational from the register contents, so a same-cycle
// update to the looked-up entry only becomes visible one cycle later.
module btb
  import rv32i_types::*;
#(
  parameter int width   = 32,
  parameter int BTB_IDX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] lookup_pc,
  output logic             lookup_pred,
  output logic [width-1:0] lookup_target,
  input  logic             upd_valid,
  input  logic [width-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [width-1:0] upd_target
);

  localparam int ENTRIES = 1 << BTB_IDX;
  localparam int TAG_W   = width - BTB_IDX - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [width-1:0]   target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];

  logic [BTB_IDX-1:0] lk_idx;
  logic [BTB_IDX-1:0] up_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [TAG_W-1:0]   up_tag;
  logic               lk_hit;
  logic               up_hit;

  assign lk_idx        = lookup_pc[BTB_IDX+1:2];
  assign lk_tag        = lookup_pc[width-1:BTB_IDX+2];
  assign up_idx        = upd_pc[BTB_IDX+1:2];
  assign up_tag        = upd_pc[width-1:BTB_IDX+2];
  assign lk_hit        = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign up_hit        = valid[up_idx] && (tag[up_idx] == up_tag);
  assign lookup_pred   = lk_hit && ctr[lk_idx][1];
  assign lookup_target = target[lk_idx];

  // Entry storage: allocate on taken miss, train counters on hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (up_hit) begin
          ctr[up_idx]    <= ctr_inc(ctr[up_idx]);
          target[up_idx] <= upd_target;
        end else begin
          valid[up_idx]  <= 1'b1;
          tag[up_idx]    <= up_tag;
          target[up_idx] <= upd_target;
          ctr[up_idx]    <= 2'b10;
        end
      end else if (up_hit) begin
        ctr[up_idx] <= ctr_dec(ctr[up_idx]);
      end
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, instruction-memory handshake, BTB-based
// next-PC prediction and the IF/ID output register.
module if_fetch
  import rv32i_types::*;
#(
  parameter int               width    = 32,
  parameter int               BTB_IDX  = 4,
  parameter logic [width-1:0] RESET_PC = width'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_read,
  output logic [width-1:0] imem_address,
  input  logic [width-1:0] imem_rdata,
  input  logic             imem_resp,
  input  logic             IF_stall_i,
  input  logic             IF_redirect_i,
  input  logic [width-1:0] IF_redirect_pc_i,
  input  logic             IF_halt_i,
  input  logic             IF_upd_valid_i,
  input  logic [width-1:0] IF_upd_pc_i,
  input  logic             IF_upd_taken_i,
  input  logic [width-1:0] IF_upd_target_i,
  output logic [width-1:0] IF_instr_o,
  output logic [width-1:0] IF_pc_o,
  output logic             IF_br_pred_o,
  output logic             IF_valid_o
);

  localparam logic [width-1:0] NOP     = width'(NOP_INSTR);
  localparam logic [width-1:0] PC_STEP = width'(32'd4);

  fetch_state_t     state, state_n;
  logic [width-1:0] pc, pc_n;
  logic             pend, pend_n;         // redirect waiting for in-flight response
  logic [width-1:0] redir_pc, redir_pc_n;
  logic             halt_pend, halt_pend_n;
  logic             read_n;
  logic [width-1:0] instr_n, pc_out_n;
  logic             pred_n, valid_n;
  logic [width-1:0] buf_instr, buf_instr_n;
  logic             buf_pred, buf_pred_n;
  logic [width-1:0] buf_next, buf_next_n;
  logic             pred;
  logic [width-1:0] pred_target;
  logic [width-1:0] next_pc;

  btb #(.width(width), .BTB_IDX(BTB_IDX)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc    (pc),
    .lookup_pred  (pred),
    .lookup_target(pred_target),
    .upd_valid    (IF_upd_valid_i),
    .upd_pc       (IF_upd_pc_i),
    .upd_taken    (IF_upd_taken_i),
    .upd_target   (IF_upd_target_i)
  );

  assign imem_address = pc;
  assign next_pc      = pred ? pred_target : (pc + PC_STEP);

  // State, PC and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      pend         <= 1'b0;
      redir_pc     <= RESET_PC;
      halt_pend    <= 1'b0;
      imem_read    <= 1'b0;
      IF_instr_o   <= NOP;
      IF_pc_o      <= RESET_PC;
      IF_br_pred_o <= 1'b0;
      IF_valid_o   <= 1'b0;
      buf_instr    <= NOP;
      buf_pred     <= 1'b0;
      buf_next     <= RESET_PC;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      pend         <= pend_n;
      redir_pc     <= redir_pc_n;
      halt_pend    <= halt_pend_n;
      imem_read    <= read_n;
      IF_instr_o   <= instr_n;
      IF_pc_o      <= pc_out_n;
      IF_br_pred_o <= pred_n;
      IF_valid_o   <= valid_n;
      buf_instr    <= buf_instr_n;
      buf_pred     <= buf_pred_n;
      buf_next     <= buf_next_n;
    end
  end

  // Next-state and output decode; redirect outranks halt, halt outranks stall.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pend_n      = pend;
    redir_pc_n  = redir_pc;
    halt_pend_n = halt_pend;
    instr_n     = IF_instr_o;
    pc_out_n    = IF_pc_o;
    pred_n      = IF_br_pred_o;
    valid_n     = IF_valid_o;
    buf_instr_n = buf_instr;
    buf_pred_n  = buf_pred;
    buf_next_n  = buf_next;
    case (state)
      ST_REQ: begin
        if (IF_redirect_i) begin
          instr_n     = NOP;
          valid_n     = 1'b0;
          pred_n      = 1'b0;
          halt_pend_n = 1'b0;
          if (imem_resp) begin
            pc_n   = IF_redirect_pc_i;
            pend_n = 1'b0;
          end else begin
            pend_n     = 1'b1;
            redir_pc_n = IF_redirect_pc_i;
          end
        end else if (imem_resp) begin
          if (halt_pend || IF_halt_i) begin
            state_n     = ST_HALT;
            valid_n     = 1'b0;
            pend_n      = 1'b0;
            halt_pend_n = 1'b0;
          end else if (pend) begin
            // Response belongs to the squashed path: drop it and restart.
            pc_n    = redir_pc;
            pend_n  = 1'b0;
            instr_n = NOP;
            valid_n = 1'b0;
            pred_n  = 1'b0;
          end else if (IF_stall_i) begin
            state_n     = ST_HOLD;
            buf_instr_n = imem_rdata;
            buf_pred_n  = pred;
            buf_next_n  = next_pc;
          end else begin
            instr_n  = imem_rdata;
            pc_out_n = pc;
            pred_n   = pred;
            valid_n  = 1'b1;
            pc_n     = next_pc;
          end
        end else begin
          if (IF_halt_i) begin
            halt_pend_n = 1'b1;
            valid_n     = 1'b0;
          end else if (IF_stall_i) begin
            valid_n = IF_valid_o;
          end else begin
            valid_n = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (IF_redirect_i) begin
          state_n = ST_REQ;
          pc_n    = IF_redirect_pc_i;
          instr_n = NOP;
          valid_n = 1'b0;
          pred_n  = 1'b0;
        end else if (IF_halt_i) begin
          state_n = ST_HALT;
          valid_n = 1'b0;
        end else if (IF_stall_i) begin
          state_n = ST_HOLD;
        end else begin
          state_n  = ST_REQ;
          instr_n  = buf_instr;
          pc_out_n = pc;
          pred_n   = buf_pred;
          valid_n  = 1'b1;
          pc_n     = buf_next;
        end
      end
      ST_HALT: begin
        state_n = ST_HALT;
        valid_n = 1'b0;
      end
      default: begin
        state_n = ST_REQ;
        valid_n = 1'b0;
      end
    endcase
    read_n = (state_n == ST_REQ);
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with an output scoreboard.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        IF_stall_i, IF_redirect_i, IF_halt_i;
  logic [31:0] IF_redirect_pc_i;
  logic        IF_upd_valid_i, IF_upd_taken_i;
  logic [31:0] IF_upd_pc_i, IF_upd_target_i;
  logic [31:0] IF_instr_o, IF_pc_o;
  logic        IF_br_pred_o, IF_valid_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  if_fetch dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .IF_stall_i(IF_stall_i), .IF_redirect_i(IF_redirect_i),
    .IF_redirect_pc_i(IF_redirect_pc_i), .IF_halt_i(IF_halt_i),
    .IF_upd_valid_i(IF_upd_valid_i), .IF_upd_pc_i(IF_upd_pc_i),
    .IF_upd_taken_i(IF_upd_taken_i), .IF_upd_target_i(IF_upd_target_i),
    .IF_instr_o(IF_instr_o), .IF_pc_o(IF_pc_o),
    .IF_br_pred_o(IF_br_pred_o), .IF_valid_o(IF_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory returns the word at the current address; push expectation if it should reach decode.
  task automatic give(input bit push, input bit pred);
    exp_t e;
    imem_resp  = 1'b1;
    imem_rdata = instr_of(imem_address);
    if (push) begin
      e.pc    = imem_address;
      e.instr = instr_of(imem_address);
      e.pred  = pred;
      exp_q.push_back(e);
    end
  endtask

  task automatic nores();
    imem_resp  = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic upd(input bit v, input bit taken, input logic [31:0] p, input logic [31:0] t);
    IF_upd_valid_i  = v;
    IF_upd_taken_i  = taken;
    IF_upd_pc_i     = p;
    IF_upd_target_i = t;
  endtask

  // Monitor: every instruction consumed by decode (valid, not stalled) is checked in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && IF_valid_o === 1'b1 && IF_stall_i === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got pc %08h, expected no instruction", IF_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", IF_pc_o, e.pc);
          chk("out_instr", IF_instr_o, e.instr);
          chk("out_pred", {31'd0, IF_br_pred_o}, {31'd0, e.pred});
        end
      end
    end
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    IF_stall_i = 1'b0; IF_redirect_i = 1'b0; IF_redirect_pc_i = 32'd0; IF_halt_i = 1'b0;
    upd(1'b0, 1'b0, 32'd0, 32'd0);
    nores();
    #12;
    chk("rst_read", {31'd0, imem_read}, 32'd0);
    chk("rst_valid", {31'd0, IF_valid_o}, 32'd0);
    chk("rst_instr", IF_instr_o, 32'h0000_0013);
    chk("rst_pc", IF_pc_o, 32'h4000_0060);
    chk("rst_pred", {31'd0, IF_br_pred_o}, 32'd0);
    #11 rst = 1'b1;
    tick();
    // Zero-wait stream.
    chk("c1_read", {31'd0, imem_read}, 32'd1);
    chk("c1_addr", imem_address, 32'h4000_0060);
    chk("c1_valid", {31'd0, IF_valid_o}, 32'd0);
    give(1'b1, 1'b0); tick();
    chk("c2_addr", imem_address, 32'h4000_0064);
    chk("c2_valid", {31'd0, IF_valid_o}, 32'd1);
    give(1'b1, 1'b0); tick();
    chk("c3_addr", imem_address, 32'h4000_0068);
    give(1'b1, 1'b0); tick();
    // Train BTB: 0x70 taken to 0x100.
    chk("c4_addr", imem_address, 32'h4000_006C);
    nores(); upd(1'b1, 1'b1, 32'h4000_0070, 32'h4000_0100); tick();
    upd(1'b0, 1'b0, 32'd0, 32'd0);
    give(1'b1, 1'b0); tick();
    chk("btb_fetch_addr", imem_address, 32'h4000_0070);
    give(1'b1, 1'b1); tick();
    chk("btb_pred_addr", imem_address, 32'h4000_0100);
    nores(); upd(1'b1, 1'b0, 32'h4000_0070, 32'd0); tick();
    tick();
    upd(1'b0, 1'b0, 32'd0, 32'd0);
    IF_redirect_i = 1'b1; IF_redirect_pc_i = 32'h4000_0070; tick();
    IF_redirect_i = 1'b0;
    chk("pend_hold_addr", imem_address, 32'h4000_0100);
    give(1'b0, 1'b0); tick();
    chk("refetch_addr", imem_address, 32'h4000_0070);
    chk("refetch_valid0", {31'd0, IF_valid_o}, 32'd0);
    give(1'b1, 1'b0); tick();
    chk("nt_next_addr", imem_address, 32'h4000_0074);
    give(1'b1, 1'b0); tick();
    give(1'b1, 1'b0); tick();
    give(1'b1, 1'b0); tick();
    // Redirect against a 3-wait request to 0x80.
    chk("w_addr", imem_address, 32'h4000_0080);
    nores(); IF_redirect_i = 1'b1; IF_redirect_pc_i = 32'h4000_0200; tick();
    IF_redirect_i = 1'b0;
    chk("w_hold1", imem_address, 32'h4000_0080);
    chk("w_valid0", {31'd0, IF_valid_o}, 32'd0);
    chk("w_nop", IF_instr_o, 32'h0000_0013);
    tick();
    chk("w_hold2", imem_address, 32'h4000_0080);
    tick();
    chk("w_hold3", imem_address, 32'h4000_0080);
    give(1'b0, 1'b0); tick();
    chk("w_new_addr", imem_address, 32'h4000_0200);
    chk("w_discard", {31'd0, IF_valid_o}, 32'd0);
    give(1'b1, 1'b0); tick();
    chk("s_addr", imem_address, 32'h4000_0204);
    give(1'b1, 1'b0); tick();
    // Four-cycle stall as the response for 0x208 arrives.
    chk("s_pc_before", IF_pc_o, 32'h4000_0204);
    IF_stall_i = 1'b1; give(1'b1, 1'b0); tick();
    nores();
    for (int k = 0; k < 3; k++) begin
      chk("s_hold_read", {31'd0, imem_read}, 32'd0);
      chk("s_frozen_pc", IF_pc_o, 32'h4000_0204);
      chk("s_frozen_instr", IF_instr_o, instr_of(32'h4000_0204));
      tick();
    end
    IF_stall_i = 1'b0;
    chk("s_release_pc", IF_pc_o, 32'h4000_0204);
    tick();
    chk("s_buf_pc", IF_pc_o, 32'h4000_0208);
    chk("s_after_addr", imem_address, 32'h4000_020C);
    give(1'b1, 1'b0); tick();
    nores(); tick();
    // Redirect and stall together, with a response that must be dropped.
    chk("rs_valid_before", {31'd0, IF_valid_o}, 32'd0);
    IF_stall_i = 1'b1; IF_redirect_i = 1'b1; IF_redirect_pc_i = 32'h4000_0300;
    give(1'b0, 1'b0); tick();
    IF_stall_i = 1'b0; IF_redirect_i = 1'b0;
    chk("rs_addr", imem_address, 32'h4000_0300);
    chk("rs_nop", IF_instr_o, 32'h0000_0013);
    chk("rs_valid0", {31'd0, IF_valid_o}, 32'd0);
    give(1'b1, 1'b0); tick();
    // Halt with a request outstanding.
    chk("h_addr", imem_address, 32'h4000_0304);
    nores(); IF_halt_i = 1'b1; tick();
    IF_halt_i = 1'b0;
    chk("h_outstanding_read", {31'd0, imem_read}, 32'd1);
    chk("h_valid0", {31'd0, IF_valid_o}, 32'd0);
    give(1'b0, 1'b0); tick();
    nores();
    for (int k = 0; k < 5; k++) begin
      if (k < 2) upd(1'b1, 1'b1, 32'h4000_0070, 32'h4000_0100);
      else upd(1'b0, 1'b0, 32'd0, 32'd0);
      chk("h_read0", {31'd0, imem_read}, 32'd0);
      chk("h_valid_stay0", {31'd0, IF_valid_o}, 32'd0);
      tick();
    end
    // Reset pulse mid-halt.
    rst = 1'b0;
    #1;
    chk("r_read", {31'd0, imem_read}, 32'd0);
    chk("r_pc_o", IF_pc_o, 32'h4000_0060);
    chk("r_addr", imem_address, 32'h4000_0060);
    #4 rst = 1'b1;
    tick();
    chk("r_restart_read", {31'd0, imem_read}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("r_seq_addr", imem_address, 32'h4000_0060 + 32'(k * 4));
      give(1'b1, 1'b0); tick();
    end
    chk("r_btb_empty_addr", imem_address, 32'h4000_0074);
    nores(); tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage feeding the IF/ID pipeline register, directly upstream of the decode stage. It holds the PC and runs the instruction-memory read handshake. A small direct-mapped BTB with 2-bit counters supplies the next-PC prediction, and the prediction bit travels with the instruction. Redirects from decode (mispredict flush), hazard stalls and halt are honoured with cycle-exact behaviour.

## Interface
Parameters:
- width, 32, datapath/address width
- BTB_IDX, 4, log2 of BTB entries (16)
- RESET_PC, 32'h4000_0060, first fetch address

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_read  out  1  read request, held until imem_resp
- imem_address  out  width  fetch address, word aligned
- imem_rdata  in  width  instruction, valid with imem_resp
- imem_resp  in  1  one-cycle completion pulse
- IF_stall_i  in  1  hazard stall; hold IF outputs and PC
- IF_redirect_i  in  1  decode flush; restart at IF_redirect_pc_i
- IF_redirect_pc_i  in  width  corrected PC
- IF_halt_i  in  1  halt detected in decode
- IF_upd_valid_i  in  1  resolved control-flow update
- IF_upd_pc_i  in  width  PC of resolved instruction
- IF_upd_taken_i  in  1  resolved direction (jal/jalr = 1)
- IF_upd_target_i  in  width  resolved target
- IF_instr_o  out  width  instruction to IF/ID
- IF_pc_o  out  width  its PC
- IF_br_pred_o  out  1  predicted-taken bit
- IF_valid_o  out  1  output holds a real instruction

## Operation
- FSM states: REQ, HOLD, HALT.
  - REQ: imem_read=1 at address pc.
  - HOLD: response captured, stall active.
  - HALT: no requests.
- Reset: state REQ, pc=RESET_PC, pending-redirect flag 0, all BTB valid bits 0, all counters 2'b01.
- Output reset values: IF_instr_o=32'h0000_0013 (NOP), IF_pc_o=RESET_PC, IF_br_pred_o=0, IF_valid_o=0, imem_read=0 while rst is low.
- Prediction:
  - index = pc[BTB_IDX+1:2]; tag = pc[width-1:BTB_IDX+2].
  - hit = valid & tag match.
  - pred = hit & ctr[1].
  - next_pc = pred ? btb_target : pc+4. Addition wraps modulo 2^width.
- REQ, imem_resp=1, no stall:
  - IF outputs take rdata, pc and pred; valid=1.
  - pc ← next_pc.
- REQ, imem_resp=1, IF_stall_i=1:
  - Buffer rdata and pred; go to HOLD. IF outputs are unchanged.
- HOLD: when stall drops, present the buffer, pc ← next_pc (computed from the buffered pred), go to REQ.
- Redirect (highest priority except reset):
  - In REQ with no resp: set the pending flag and latch the redirect PC. Keep imem_read high with the old address until resp. Discard that response and restart at the latched PC the next cycle.
  - In REQ with resp, or in HOLD: drop the instruction and go to REQ at IF_redirect_pc_i.
  - Every redirect sets IF_valid_o=0 and IF_instr_o=NOP on the next edge.
- Redirect and stall in the same cycle: redirect wins.
- Halt: IF_halt_i=1 completes any outstanding request, discards it, then enters HALT. IF_valid_o is 0 from then on. Only reset leaves HALT.
- BTB update on IF_upd_valid_i:
  - Taken, hit: counter +1, saturating at 3; target rewritten.
  - Taken, miss: allocate entry with tag, target, counter 2'b10.
  - Not taken, hit: counter −1, saturating at 0.
  - Not taken, miss: no change.
- Update and lookup on the same index in the same cycle: the lookup sees the old contents; the write is visible on the next cycle.

## Timing
- imem_address is combinational from the pc register; imem_read is a registered state decode.
- Fetch latency: instruction on IF_* on the edge after the edge where imem_resp=1, i.e. 1 cycle after resp.
- First request is issued the first cycle after rst deasserts. A zero-wait memory gives one instruction per cycle.
- Stall: IF_* held unchanged on every edge while IF_stall_i=1.
- Redirect: the new address appears on imem_address one cycle after IF_redirect_i, or one cycle after the pending resp is consumed.
- Asynchronous reset mid-transaction: immediate return to reset values. An in-flight response is ignored.

## Structure
- Shared package (rv32i_types): fetch FSM state enum, NOP constant 32'h0000_0013, RESET_PC default.
- One sub-module, `btb`: storage, lookup port, update port, counter saturation logic. if_fetch owns the FSM, PC and output registers.

## Test plan
- Reset release, zero-wait memory → addresses 0x40000060, 64, 68 on consecutive cycles; IF_valid_o rises 1 cycle after the first resp; IF_br_pred_o=0.
- Update pc=0x40000070, taken, target 0x40000100, then refetch 0x40000070 → pred=1, next address 0x40000100. Two not-taken updates → pred=0, next 0x40000074.
- IF_redirect_i with pc 0x40000200 while a 3-wait-state request to 0x40000080 is outstanding → 0x40000080 held until resp, its data discarded (IF_valid_o=0), next address 0x40000200.
- IF_stall_i high for 4 cycles as resp arrives → IF_* frozen, HOLD buffer presented on release, no duplicate or lost instruction.
- Redirect and stall asserted together → redirect taken, IF_instr_o=0x00000013, IF_valid_o=0.
- IF_halt_i → imem_read stays 0 indefinitely; rst pulse low mid-halt → fetch restarts at 0x40000060, BTB empty.
